// File: rtl/dma_req_agent.sv
// dma_req_agent: peripheral-side DMA request/grant/strobe responder.
// Counts words, acks strobes, reports done/err; wrong key enters a decoy.
module dma_req_agent #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             dack,
  input  logic             strobe,
  input  logic             abort,
  input  logic             keyinput0,
  output logic             dreq,
  output logic             busy,
  output logic             rdy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, XFER, WAIT_REL, DONE, ERR, DECOY
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [TW-1:0]    tcnt_q, tcnt_n;
  logic             rdy_q, rdy_n;
  logic             hit_q, hit_n;
  logic             live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem_q  <= '0;
      cnt_q  <= '0;
      tcnt_q <= '0;
      rdy_q  <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      state  <= state_n;
      rem_q  <= rem_n;
      cnt_q  <= cnt_n;
      tcnt_q <= tcnt_n;
      rdy_q  <= rdy_n;
      hit_q  <= hit_n;
    end
  end

  // abort only acts while an operation is actually in flight
  assign live = (state == REQ) || (state == XFER) ||
                (state == WAIT_REL) || (state == DECOY);

  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    cnt_n   = cnt_q;
    tcnt_n  = tcnt_q;
    rdy_n   = 1'b0;
    hit_n   = hit_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          rem_n   = len;
          cnt_n   = '0;
          tcnt_n  = '0;
          hit_n   = 1'b0;
          state_n = (len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (dack) begin
          state_n = keyinput0 ? XFER : DECOY;
        end else if (tcnt_q == TLAST) begin
          state_n = ERR;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      XFER: begin
        if (!dack) begin
          state_n = REQ;
          tcnt_n  = '0;
        end else if (strobe && rem_q != '0) begin
          rem_n = rem_q - 1'b1;
          cnt_n = cnt_q + 1'b1;
          rdy_n = 1'b1;
          if (rem_q == CNT_W'(1)) state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!dack) state_n = DONE;
      end
      DONE:     state_n = IDLE;
      ERR:      state_n = IDLE;
      DECOY: begin
        if (dack && strobe && !hit_q) begin
          cnt_n = cnt_q + 1'b1;
          rdy_n = 1'b1;
          hit_n = 1'b1;
        end
      end
      default:  state_n = IDLE;
    endcase
    if (abort && live) begin
      state_n = ERR;
      rem_n   = rem_q;
      cnt_n   = cnt_q;
      tcnt_n  = tcnt_q;
      rdy_n   = 1'b0;
      hit_n   = hit_q;
    end
  end

  assign dreq      = (state == REQ) || (state == XFER) ||
                     (state == DECOY);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign rdy       = rdy_q;
  assign remaining = rem_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_dma_req_agent.sv
// tb_dma_req_agent: directed scenario tests for dma_req_agent.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_dma_req_agent;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       dack = 1'b0;
  logic       strobe = 1'b0;
  logic       abort = 1'b0;
  logic       keyinput0 = 1'b1;
  logic       dreq, busy, rdy, done, err;
  logic [7:0] remaining, xfer_cnt;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  dma_req_agent #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .dack(dack), .strobe(strobe), .abort(abort),
    .keyinput0(keyinput0), .dreq(dreq), .busy(busy),
    .rdy(rdy), .done(done), .err(err),
    .remaining(remaining), .xfer_cnt(xfer_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if ({dreq, busy, rdy, done, err} !== 5'b0 ||
        remaining !== 8'd0 || xfer_cnt !== 8'd0) begin
      $display("FAIL reset: ctl=%b rem=%0d cnt=%0d, want 0",
               {dreq, busy, rdy, done, err}, remaining, xfer_cnt);
      miss++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    vecs++;
    if (dreq !== 1'b1 || busy !== 1'b1 || remaining !== 8'd4) begin
      $display("FAIL normal_req: dreq=%b busy=%b rem=%0d want 1 1 4",
               dreq, busy, remaining);
      miss++;
    end
    tick();
    dack = 1'b1;
    tick();
    strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (rdy !== 1'b1 || remaining !== 8'(3 - i) ||
          xfer_cnt !== 8'(i + 1)) begin
        $display("FAIL normal_word%0d: rdy=%b rem=%0d cnt=%0d want 1 %0d %0d",
                 i, rdy, remaining, xfer_cnt, 3 - i, i + 1);
        miss++;
      end
    end
    strobe = 1'b0;
    vecs++;
    if (dreq !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL normal_waitrel: dreq=%b busy=%b want 0 1", dreq, busy);
      miss++;
    end
    dack = 1'b0;
    tick();
    vecs++;
    if (done !== 1'b1 || err !== 1'b0 || rdy !== 1'b0) begin
      $display("FAIL normal_done: done=%b err=%b rdy=%b want 1 0 0",
               done, err, rdy);
      miss++;
    end
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || xfer_cnt !== 8'd4) begin
      $display("FAIL normal_idle: done=%b busy=%b cnt=%0d want 0 0 4",
               done, busy, xfer_cnt);
      miss++;
    end
  endtask

  task automatic test_dack_drop();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0; dack = 1'b1;
    tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0; dack = 1'b0;
    tick();
    vecs++;
    if (dreq !== 1'b1 || remaining !== 8'd2 || xfer_cnt !== 8'd1 ||
        rdy !== 1'b0) begin
      $display("FAIL drop_req: dreq=%b rem=%0d cnt=%0d rdy=%b want 1 2 1 0",
               dreq, remaining, xfer_cnt, rdy);
      miss++;
    end
    tick();
    tick();
    dack = 1'b1;
    tick();
    strobe = 1'b1;
    tick();
    tick();
    strobe = 1'b0;
    vecs++;
    if (remaining !== 8'd0 || xfer_cnt !== 8'd3 || dreq !== 1'b0) begin
      $display("FAIL drop_finish: rem=%0d cnt=%0d dreq=%b want 0 3 0",
               remaining, xfer_cnt, dreq);
      miss++;
    end
    dack = 1'b0;
    tick();
    vecs++;
    if (done !== 1'b1) begin
      $display("FAIL drop_done: done=%b want 1", done);
      miss++;
    end
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL drop_idle: done=%b busy=%b want 0 0", done, busy);
      miss++;
    end
  endtask

  task automatic test_timeout();
    int errs;
    errs = 0;
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (err === 1'b1) errs++;
    end
    vecs++;
    if (errs !== 0 || dreq !== 1'b1) begin
      $display("FAIL timeout_early: errs=%0d dreq=%b want 0 1", errs, dreq);
      miss++;
    end
    tick();
    vecs++;
    if (err !== 1'b1 || dreq !== 1'b0 || remaining !== 8'd5) begin
      $display("FAIL timeout_err: err=%b dreq=%b rem=%0d want 1 0 5",
               err, dreq, remaining);
      miss++;
    end
    tick();
    vecs++;
    if (err !== 1'b0 || busy !== 1'b0 || dreq !== 1'b0) begin
      $display("FAIL timeout_idle: err=%b busy=%b dreq=%b want 0 0 0",
               err, busy, dreq);
      miss++;
    end
  endtask

  task automatic test_abort();
    start = 1'b1; len = 8'd6;
    tick();
    start = 1'b0; dack = 1'b1;
    tick();
    strobe = 1'b1;
    tick();
    tick();
    strobe = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; dack = 1'b0;
    vecs++;
    if (err !== 1'b1 || remaining !== 8'd4 || xfer_cnt !== 8'd2 ||
        dreq !== 1'b0) begin
      $display("FAIL abort_err: err=%b rem=%0d cnt=%0d dreq=%b want 1 4 2 0",
               err, remaining, xfer_cnt, dreq);
      miss++;
    end
    tick();
    vecs++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL abort_idle: busy=%b err=%b want 0 0", busy, err);
      miss++;
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0; dack = 1'b1;
    tick();
    strobe = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if ({dreq, busy, rdy, done, err} !== 5'b0 ||
        remaining !== 8'd0 || xfer_cnt !== 8'd0) begin
      $display("FAIL reset_mid: ctl=%b rem=%0d cnt=%0d want 0",
               {dreq, busy, rdy, done, err}, remaining, xfer_cnt);
      miss++;
    end
    strobe = 1'b0; dack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrong_key();
    int pulses;
    pulses = 0;
    keyinput0 = 1'b0;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0; dack = 1'b1;
    tick();
    keyinput0 = 1'b1;
    strobe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy === 1'b1) pulses++;
      if (done === 1'b1) pulses += 100;
    end
    strobe = 1'b0;
    tick();
    vecs++;
    if (pulses !== 1 || xfer_cnt !== 8'd1 || remaining !== 8'd3 ||
        dreq !== 1'b1) begin
      $display("FAIL decoy: pulses=%0d cnt=%0d rem=%0d dreq=%b want 1 1 3 1",
               pulses, xfer_cnt, remaining, dreq);
      miss++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; dack = 1'b0;
    vecs++;
    if (err !== 1'b1 || dreq !== 1'b0) begin
      $display("FAIL decoy_abort: err=%b dreq=%b want 1 0", err, dreq);
      miss++;
    end
    tick();
  endtask

  task automatic test_len0();
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    vecs++;
    if (done !== 1'b1 || dreq !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL len0_done: done=%b dreq=%b busy=%b want 1 0 1",
               done, dreq, busy);
      miss++;
    end
    tick();
    vecs++;
    if (done !== 1'b0 || dreq !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL len0_idle: done=%b dreq=%b busy=%b want 0 0 0",
               done, dreq, busy);
      miss++;
    end
  endtask

  task automatic test_start_busy();
    start = 1'b1; len = 8'd4;
    tick();
    len = 8'd9;
    tick();
    tick();
    start = 1'b0;
    vecs++;
    if (remaining !== 8'd4 || dreq !== 1'b1) begin
      $display("FAIL start_busy: rem=%0d dreq=%b want 4 1", remaining, dreq);
      miss++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_dack_vs_timeout();
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    dack = 1'b1;
    tick();
    vecs++;
    if (err !== 1'b0 || dreq !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL dack_vs_timeout: err=%b dreq=%b busy=%b want 0 1 1",
               err, dreq, busy);
      miss++;
    end
    strobe = 1'b1;
    tick();
    vecs++;
    if (rdy !== 1'b1 || remaining !== 8'd1) begin
      $display("FAIL dack_vs_timeout_xfer: rdy=%b rem=%0d want 1 1",
               rdy, remaining);
      miss++;
    end
    strobe = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0; dack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_dack_drop();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_wrong_key();
    test_len0();
    test_start_busy();
    test_dack_vs_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
